// File: rtl/sim_end_ctrl_pkg.sv
// Shared definitions for the simulation end controller.
//   state_e : controller state encoding (IDLE=0, DRAIN=1, DONE=2), 2-bit register
package sim_end_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/sim_end_ctrl_if.sv
// Report bus between the reporting monitors and the end controller.
//   req_valid : per-monitor report valid
//   req_fail  : per-monitor report type (1 = fail / bad trap, 0 = pass / good trap)
//   req_code  : per-monitor report code, monitor i on bits [i*CODE_W +: CODE_W]
//   req_ready : per-monitor accept, one-hot or zero
//   master    : monitor side, slave : controller side
interface sim_end_ctrl_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned CODE_W  = 8
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_fail;
    logic [NUM_REQ*CODE_W-1:0] req_code;
    logic [NUM_REQ-1:0]        req_ready;

    modport master (
        output req_valid,
        output req_fail,
        output req_code,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_fail,
        input  req_code,
        output req_ready
    );

endinterface

// File: rtl/sim_end_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found when
// scanning upward from ptr, wrapping modulo N.
//   req     : request vector
//   ptr     : highest-priority index for this cycle
//   gnt     : one-hot grant, zero when no request
//   gnt_idx : index of the granted requester (0 when no grant)
module rr_arbiter #(
    parameter int unsigned  N  = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    int unsigned   sum;
    logic [IW-1:0] idx;
    logic          found;

    // Scan N positions starting at ptr; first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = 0;
        idx     = '0;
        for (int unsigned off = 0; off < N; off++) begin
            sum = 32'(ptr) + off;
            if (sum >= N) begin
                sum = sum - N;
            end
            idx = IW'(sum);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/sim_end_ctrl.sv
// Simulation end controller: collects pass/fail reports from NUM_REQ monitors,
// records the first fail, lets the testbench drain for wait_cycles after it,
// and raises finish once the run may end (all passed, or drain elapsed).
//   clk, rst_l  : clock, asynchronous active-low reset
//   rpt         : report bus (slave side), one report accepted per cycle
//   wait_cycles : drain window, sampled when the first fail is accepted
//   fail_flag   : first fail accepted
//   pass_flag   : every monitor passed with no fail
//   finish      : simulation may end (holds until reset)
//   first_id / first_code / first_cycle : details of the first fail
//   err_count   : fails accepted, saturating
module sim_end_ctrl
    import sim_end_ctrl_pkg::*;
#(
    parameter int unsigned  NUM_REQ = 4,
    parameter int unsigned  CODE_W  = 8,
    parameter int unsigned  CYC_W   = 32,
    parameter int unsigned  CNT_W   = 16,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic              clk,
    input  logic              rst_l,
    sim_end_ctrl_if.slave     rpt,
    input  logic [CNT_W-1:0]  wait_cycles,
    output logic              fail_flag,
    output logic              pass_flag,
    output logic              finish,
    output logic [ID_W-1:0]   first_id,
    output logic [CODE_W-1:0] first_code,
    output logic [CYC_W-1:0]  first_cycle,
    output logic [CNT_W-1:0]  err_count
);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [CYC_W-1:0]    cyc_q;
    logic [CNT_W-1:0]    drain_q, drain_d;
    logic [NUM_REQ-1:0]  seen_q, seen_d;
    logic [CNT_W-1:0]    err_d, err_inc;
    logic [ID_W-1:0]     first_id_d;
    logic [CODE_W-1:0]   first_code_d;
    logic [CYC_W-1:0]    first_cycle_d;
    logic                fail_d, pass_d, finish_d;

    logic [NUM_REQ-1:0]  arb_req, gnt;
    logic [ID_W-1:0]     gnt_idx;
    logic                accept, acc_fail;
    logic [CODE_W-1:0]   acc_code;
    logic [CODE_W-1:0]   code_arr [NUM_REQ];

    // No requester is served once the run is over.
    assign arb_req = (state_q == ST_DONE) ? '0 : rpt.req_valid;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req     (arb_req),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Ready is held low while reset is asserted so nothing looks accepted.
    assign rpt.req_ready = rst_l ? gnt : '0;
    assign accept        = (gnt != '0);

    // Unpack the flat code bus for indexing by the granted requester.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_code
        assign code_arr[g] = rpt.req_code[g*CODE_W +: CODE_W];
    end

    assign acc_fail = rpt.req_fail[gnt_idx];
    assign acc_code = code_arr[gnt_idx];
    assign err_inc  = (err_count == '1) ? err_count : err_count + CNT_W'(1);

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        drain_d       = drain_q;
        seen_d        = seen_q;
        err_d         = err_count;
        first_id_d    = first_id;
        first_code_d  = first_code;
        first_cycle_d = first_cycle;
        fail_d        = fail_flag;
        pass_d        = pass_flag;

        if (accept) begin
            ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (accept && acc_fail) begin
                    first_id_d    = gnt_idx;
                    first_code_d  = acc_code;
                    first_cycle_d = cyc_q;
                    fail_d        = 1'b1;
                    err_d         = err_inc;
                    drain_d       = wait_cycles;
                    // A zero window ends the run on the very next cycle.
                    state_d       = (wait_cycles == '0) ? ST_DONE : ST_DRAIN;
                end else if (accept) begin
                    seen_d = seen_q | gnt;
                    if (&(seen_q | gnt)) begin
                        pass_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DRAIN: begin
                if (accept && acc_fail) begin
                    err_d = err_inc;
                end
                // Finish lands wait_cycles+1 cycles after the first fail.
                if (drain_q <= CNT_W'(1)) begin
                    drain_d = '0;
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        finish_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cyc_q       <= '0;
            drain_q     <= '0;
            seen_q      <= '0;
            err_count   <= '0;
            first_id    <= '0;
            first_code  <= '0;
            first_cycle <= '0;
            fail_flag   <= 1'b0;
            pass_flag   <= 1'b0;
            finish      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cyc_q       <= cyc_q + CYC_W'(1);
            drain_q     <= drain_d;
            seen_q      <= seen_d;
            err_count   <= err_d;
            first_id    <= first_id_d;
            first_code  <= first_code_d;
            first_cycle <= first_cycle_d;
            fail_flag   <= fail_d;
            pass_flag   <= pass_d;
            finish      <= finish_d;
        end
    end

endmodule

// File: tb/tb_sim_end_ctrl.sv
// Self-checking bench for sim_end_ctrl: directed scenarios plus randomized
// episodes compared against a behavioural model, and a second instance with a
// 4-bit error counter for saturation.
module tb_sim_end_ctrl;

    localparam int unsigned NR = 4;
    localparam int unsigned CW = 8;
    localparam int unsigned YW = 32;
    localparam int unsigned NW = 16;
    localparam int unsigned SW = 4;

    logic clk   = 1'b0;
    logic rst_l = 1'b1;
    always #5 clk = ~clk;

    sim_end_ctrl_if #(.NUM_REQ(NR), .CODE_W(CW)) rpt_if ();
    sim_end_ctrl_if #(.NUM_REQ(NR), .CODE_W(CW)) sat_if ();

    logic [NW-1:0] wt;
    logic          fail_flag, pass_flag, finish;
    logic [1:0]    first_id;
    logic [CW-1:0] first_code;
    logic [YW-1:0] first_cycle;
    logic [NW-1:0] err_count;

    logic [SW-1:0] sat_wt;
    logic          sat_fail, sat_pass, sat_finish;
    logic [1:0]    sat_id;
    logic [CW-1:0] sat_code;
    logic [YW-1:0] sat_cycle;
    logic [SW-1:0] sat_err;

    sim_end_ctrl #(.NUM_REQ(NR), .CODE_W(CW), .CYC_W(YW), .CNT_W(NW)) u_dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .rpt         (rpt_if.slave),
        .wait_cycles (wt),
        .fail_flag   (fail_flag),
        .pass_flag   (pass_flag),
        .finish      (finish),
        .first_id    (first_id),
        .first_code  (first_code),
        .first_cycle (first_cycle),
        .err_count   (err_count)
    );

    sim_end_ctrl #(.NUM_REQ(NR), .CODE_W(CW), .CYC_W(YW), .CNT_W(SW)) u_sat (
        .clk         (clk),
        .rst_l       (rst_l),
        .rpt         (sat_if.slave),
        .wait_cycles (sat_wt),
        .fail_flag   (sat_fail),
        .pass_flag   (sat_pass),
        .finish      (sat_finish),
        .first_id    (sat_id),
        .first_code  (sat_code),
        .first_cycle (sat_cycle),
        .err_count   (sat_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: which reports end the run and when.
    int          m_ptr;
    logic        m_done, m_fail, m_pass;
    logic [3:0]  m_seen;
    int          m_err;
    logic [1:0]  m_fid;
    logic [7:0]  m_fcode;
    logic [31:0] m_fcyc, m_cyc, m_end;

    function automatic logic [3:0] pick(input logic [3:0] v, input int p, input logic done);
        logic [3:0] r;
        r = 4'h0;
        if (!done) begin
            for (int k = 0; k < 4; k++) begin
                if (r == 4'h0 && v[(p + k) % 4]) r[(p + k) % 4] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_done = 0; m_fail = 0; m_pass = 0; m_seen = 0; m_err = 0;
        m_fid = 0; m_fcode = 0; m_fcyc = 0; m_cyc = 0; m_end = 0;
    endtask

    task automatic model_step();
        logic [3:0]  g;
        logic [31:0] codes;
        int          gi;
        g     = pick(rpt_if.req_valid, m_ptr, m_done);
        codes = rpt_if.req_code;
        gi    = 0;
        for (int k = 0; k < 4; k++) if (g[k]) gi = k;
        if (g != 4'h0) begin
            m_ptr = (gi + 1) % 4;
            if (rpt_if.req_fail[gi]) begin
                if (m_err < 65535) m_err++;
                if (!m_fail) begin
                    m_fail  = 1;
                    m_fid   = 2'(gi);
                    m_fcode = codes[gi*8 +: 8];
                    m_fcyc  = m_cyc;
                    m_end   = m_cyc + 32'(wt) + 32'd1;
                end
            end else if (!m_fail) begin
                m_seen[gi] = 1'b1;
                if (m_seen == 4'hF) begin
                    m_pass = 1;
                    m_done = 1;
                end
            end
        end
        m_cyc = m_cyc + 32'd1;
        if (m_fail && !m_done && m_cyc == m_end) m_done = 1;
    endtask

    task automatic model_check();
        check("fail_flag",   64'(fail_flag),   64'(m_fail));
        check("pass_flag",   64'(pass_flag),   64'(m_pass));
        check("finish",      64'(finish),      64'(m_done));
        check("err_count",   64'(err_count),   64'(m_err));
        check("first_id",    64'(first_id),    64'(m_fid));
        check("first_code",  64'(first_code),  64'(m_fcode));
        check("first_cycle", 64'(first_cycle), 64'(m_fcyc));
    endtask

    // One clock: ready checked at negedge, outputs checked just after posedge.
    task automatic tick();
        @(negedge clk);
        check("req_ready", 64'(rpt_if.req_ready), 64'(pick(rpt_if.req_valid, m_ptr, m_done)));
        @(posedge clk);
        model_step();
        #1;
        model_check();
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] f, input logic [31:0] c,
                         input logic [15:0] w);
        rpt_if.req_valid = v;
        rpt_if.req_fail  = f;
        rpt_if.req_code  = c;
        wt               = w;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_fail"},  64'(fail_flag),        64'd0);
        check({tag, "_pass"},  64'(pass_flag),        64'd0);
        check({tag, "_fin"},   64'(finish),           64'd0);
        check({tag, "_err"},   64'(err_count),        64'd0);
        check({tag, "_id"},    64'(first_id),         64'd0);
        check({tag, "_code"},  64'(first_code),       64'd0);
        check({tag, "_cyc"},   64'(first_cycle),      64'd0);
        check({tag, "_ready"}, 64'(rpt_if.req_ready), 64'd0);
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        #1;
        check_zero("rst");
        drive(4'h0, 4'h0, 32'h0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_l = 1'b1;
        model_reset();
    endtask

    initial begin
        int pct;
        logic [3:0] f;
        drive(4'h0, 4'h0, 32'h0, 16'h0);
        sat_if.req_valid = 4'h0;
        sat_if.req_fail  = 4'h0;
        sat_if.req_code  = 32'h0;
        sat_wt           = 4'h0;
        #2;
        do_reset();

        // Fail from req 2, code 0x5A at cycle 10, drain of 2.
        while (m_cyc < 32'd10) tick();
        drive(4'b0100, 4'b0100, 32'h005A_0000, 16'd2);
        tick();
        drive(4'h0, 4'h0, 32'h0, 16'd2);
        check("r39_fail",  64'(fail_flag),   64'd1);
        check("r39_id",    64'(first_id),    64'd2);
        check("r39_code",  64'(first_code),  64'h5A);
        check("r39_cycle", 64'(first_cycle), 64'd10);
        tick();
        check("r39_nofin", 64'(finish), 64'd0);
        tick();
        check("r39_fin13", 64'(finish), 64'd1);
        drive(4'hF, 4'hF, 32'h0, 16'd0);
        tick();

        // All four pass in consecutive cycles.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(4'(1 << i), 4'h0, 32'h0, 16'd0);
            tick();
        end
        check("r40_pass", 64'(pass_flag), 64'd1);
        check("r40_fin",  64'(finish),    64'd1);
        check("r40_err",  64'(err_count), 64'd0);
        drive(4'hF, 4'h0, 32'h0, 16'd0);
        tick();

        // Simultaneous fails from req 1 and 3 with the pointer at 2.
        do_reset();
        drive(4'b0010, 4'b0000, 32'h0, 16'd5);
        tick();
        drive(4'b1010, 4'b1010, 32'h3300_1100, 16'd5);
        tick();
        check("r41_id3",  64'(first_id),  64'd3);
        check("r41_err1", 64'(err_count), 64'd1);
        tick();
        check("r41_id",   64'(first_id),   64'd3);
        check("r41_code", 64'(first_code), 64'h33);
        check("r41_err2", 64'(err_count),  64'd2);
        drive(4'h0, 4'h0, 32'h0, 16'd0);
        repeat (6) tick();

        // Zero drain window.
        do_reset();
        drive(4'b0001, 4'b0001, 32'h0000_0077, 16'd0);
        tick();
        check("r42_fin", 64'(finish), 64'd1);
        tick();
        check("r42_ready", 64'(rpt_if.req_ready), 64'd0);

        // Reset pulse in the middle of a drain, then a fresh first fail.
        do_reset();
        drive(4'b0010, 4'b0010, 32'h0000_9900, 16'd10);
        tick();
        drive(4'h0, 4'h0, 32'h0, 16'd10);
        repeat (3) tick();
        drive(4'hF, 4'hF, 32'hFFFF_FFFF, 16'd10);
        do_reset();
        drive(4'b1000, 4'b1000, 32'hC300_0000, 16'd1);
        tick();
        check("r43_id",   64'(first_id),    64'd3);
        check("r43_code", 64'(first_code),  64'hC3);
        check("r43_cyc",  64'(first_cycle), 64'd0);
        drive(4'h0, 4'h0, 32'h0, 16'd0);
        repeat (2) tick();

        // Randomized episodes with mixed fail rates and drain windows.
        for (int ep = 0; ep < 30; ep++) begin
            do_reset();
            pct = (ep % 3 == 0) ? 0 : ((ep % 3 == 1) ? 4 : 20);
            for (int t = 0; t < 40; t++) begin
                for (int b = 0; b < 4; b++) f[b] = ($urandom_range(0, 99) < pct);
                drive(4'($urandom), f, $urandom, 16'($urandom_range(0, 6)));
                tick();
            end
        end

        // Saturation of a 4-bit error counter over a 15-cycle drain.
        do_reset();
        sat_if.req_valid = 4'hF;
        sat_if.req_fail  = 4'hF;
        sat_wt           = 4'd15;
        for (int k = 0; k < 20; k++) begin
            sat_if.req_code = $urandom;
            tick();
            check("sat_err", 64'(sat_err),    64'((k + 1 < 15) ? k + 1 : 15));
            check("sat_fin", 64'(sat_finish), 64'((k + 1 >= 16) ? 1 : 0));
        end
        check("sat_ready", 64'(sat_if.req_ready), 64'd0);
        check("sat_flag",  64'(sat_fail),         64'd1);
        check("sat_pass",  64'(sat_pass),         64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
